// File: rtl/rf68000_nic_arb.sv
// rf68000_nic_arb -- round-robin arbiter that shares one NIC slave port
// among NREQ local bus requesters, with a watchdog that aborts a bus
// cycle the NIC never terminates.
//
// Ports
//   clk_i, rst_i         clock; asynchronous active-high reset
//   rq_cyc_i/stb_i/we_i  per-requester controls (NREQ bits each)
//   rq_cti_i             per-requester cycle type (3 bits per requester)
//   rq_sel_i             per-requester byte selects (4 bits per requester)
//   rq_adr_i, rq_dat_i   per-requester address / write data (32 bits each)
//   rq_ack/err/rty/vpa_o per-requester terminations
//   rq_dat_o             NIC read data, shared by all requesters
//   n_*_o                request side of the NIC slave port
//   n_ack/err/rty/vpa_i  NIC terminations, n_dat_i NIC read data
//   gnt_o                registered one-hot grant
//   busy_o               arbiter not idle

// One lane per requester: pending detect and termination steering.
module rf68000_nic_arb_lane (
  input  logic cyc,
  input  logic stb,
  input  logic sel,       // this lane owns the current grant
  input  logic busy_st,
  input  logic abort_st,
  input  logic n_ack,
  input  logic n_err,
  input  logic n_rty,
  input  logic n_vpa,
  output logic pend,
  output logic ack,
  output logic err,
  output logic rty,
  output logic vpa
);
  assign pend = cyc & stb;
  assign ack  = busy_st & sel & n_ack;
  // An abort is reported to the owner as a bus error for as long as
  // the owner keeps its cycle open.
  assign err  = sel & ((busy_st & n_err) | abort_st);
  assign rty  = busy_st & sel & n_rty;
  assign vpa  = busy_st & sel & n_vpa;
endmodule

module rf68000_nic_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   rq_cyc_i,
  input  logic [NREQ-1:0]   rq_stb_i,
  input  logic [NREQ*3-1:0] rq_cti_i,
  input  logic [NREQ-1:0]   rq_we_i,
  input  logic [NREQ*4-1:0] rq_sel_i,
  input  logic [NREQ*32-1:0] rq_adr_i,
  input  logic [NREQ*32-1:0] rq_dat_i,
  output logic [NREQ-1:0]   rq_ack_o,
  output logic [NREQ-1:0]   rq_err_o,
  output logic [NREQ-1:0]   rq_rty_o,
  output logic [NREQ-1:0]   rq_vpa_o,
  output logic [31:0]       rq_dat_o,
  output logic              n_cyc_o,
  output logic              n_stb_o,
  output logic              n_we_o,
  output logic [2:0]        n_cti_o,
  output logic [3:0]        n_sel_o,
  output logic [31:0]       n_adr_o,
  output logic [31:0]       n_dat_o,
  input  logic              n_ack_i,
  input  logic              n_err_i,
  input  logic              n_rty_i,
  input  logic              n_vpa_i,
  input  logic [31:0]       n_dat_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = ($clog2(TMO + 1) > 10) ? $clog2(TMO + 1) : 10;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT, GAP} state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   last;      // current owner while granted, else previous owner
  logic [LW-1:0]   win;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] gsel;
  logic            any_pend;
  logic            term;
  logic            tmo_hit;
  logic            busy_st;
  logic            abort_st;

  assign any_pend = |pend;
  assign term     = n_ack_i | n_err_i | n_rty_i | n_vpa_i;
  assign tmo_hit  = (cnt == CW'(TMO));
  assign busy_st  = (state == BUSY);
  assign abort_st = (state == ABORT);
  assign busy_o   = (state != IDLE);
  assign rq_dat_o = n_dat_i;

  always_comb begin
    gsel       = '0;
    gsel[last] = 1'b1;
  end

  // Round-robin search from last+1 upward with wrap. Walking offsets
  // from largest to smallest leaves the nearest pending index in win.
  always_comb begin
    win = last;
    for (int i = NREQ; i >= 1; i--) begin
      if (pend[(int'(last) + i) % NREQ])
        win = LW'((int'(last) + i) % NREQ);
    end
  end

  rf68000_nic_arb_lane u_lane [NREQ-1:0] (
    .cyc      (rq_cyc_i),
    .stb      (rq_stb_i),
    .sel      (gsel),
    .busy_st  (busy_st),
    .abort_st (abort_st),
    .n_ack    (n_ack_i),
    .n_err    (n_err_i),
    .n_rty    (n_rty_i),
    .n_vpa    (n_vpa_i),
    .pend     (pend),
    .ack      (rq_ack_o),
    .err      (rq_err_o),
    .rty      (rq_rty_o),
    .vpa      (rq_vpa_o)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic. Dropping cyc wins over the watchdog, and a
  // termination in the timeout cycle wins over the abort.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (any_pend) state_nx = BUSY;
      BUSY: begin
        if (!rq_cyc_i[last])     state_nx = GAP;
        else if (!term && tmo_hit) state_nx = ABORT;
      end
      ABORT: if (!rq_cyc_i[last]) state_nx = GAP;
      GAP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: NIC request side mirrors the owner only in BUSY, so ABORT
  // and GAP both present an idle bus to the NIC.
  always_comb begin
    n_cyc_o = 1'b0;
    n_stb_o = 1'b0;
    n_we_o  = 1'b0;
    n_cti_o = '0;
    n_sel_o = '0;
    n_adr_o = '0;
    n_dat_o = '0;
    if (state == BUSY) begin
      n_cyc_o = rq_cyc_i[last];
      n_stb_o = rq_stb_i[last];
      n_we_o  = rq_we_i[last];
      n_cti_o = rq_cti_i[int'(last)*3 +: 3];
      n_sel_o = rq_sel_i[int'(last)*4 +: 4];
      n_adr_o = rq_adr_i[int'(last)*32 +: 32];
      n_dat_o = rq_dat_i[int'(last)*32 +: 32];
    end
  end

  // Grant, owner index and watchdog
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_o <= '0;
      last  <= LW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (any_pend) begin
          gnt_o     <= '0;
          gnt_o[win] <= 1'b1;
          last      <= win;
          cnt       <= '0;
        end
        BUSY: begin
          cnt <= term ? '0 : cnt + 1'b1;
          if (!rq_cyc_i[last]) gnt_o <= '0;
        end
        ABORT: if (!rq_cyc_i[last]) gnt_o <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rf68000_nic_arb.sv
module tb_rf68000_nic_arb;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   rq_cyc_i, rq_stb_i, rq_we_i;
  logic [NREQ*3-1:0] rq_cti_i;
  logic [NREQ*4-1:0] rq_sel_i;
  logic [NREQ*32-1:0] rq_adr_i, rq_dat_i;
  logic [NREQ-1:0]   rq_ack_o, rq_err_o, rq_rty_o, rq_vpa_o;
  logic [31:0]       rq_dat_o;
  logic              n_cyc_o, n_stb_o, n_we_o;
  logic [2:0]        n_cti_o;
  logic [3:0]        n_sel_o;
  logic [31:0]       n_adr_o, n_dat_o;
  logic              n_ack_i, n_err_i, n_rty_i, n_vpa_i;
  logic [31:0]       n_dat_i;
  logic [NREQ-1:0]   gnt_o;
  logic              busy_o;

  int total = 0;
  int bad   = 0;

  rf68000_nic_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .rq_cyc_i(rq_cyc_i), .rq_stb_i(rq_stb_i), .rq_cti_i(rq_cti_i),
    .rq_we_i(rq_we_i), .rq_sel_i(rq_sel_i), .rq_adr_i(rq_adr_i),
    .rq_dat_i(rq_dat_i),
    .rq_ack_o(rq_ack_o), .rq_err_o(rq_err_o), .rq_rty_o(rq_rty_o),
    .rq_vpa_o(rq_vpa_o), .rq_dat_o(rq_dat_o),
    .n_cyc_o(n_cyc_o), .n_stb_o(n_stb_o), .n_we_o(n_we_o),
    .n_cti_o(n_cti_o), .n_sel_o(n_sel_o), .n_adr_o(n_adr_o),
    .n_dat_o(n_dat_o),
    .n_ack_i(n_ack_i), .n_err_i(n_err_i), .n_rty_i(n_rty_i),
    .n_vpa_i(n_vpa_i), .n_dat_i(n_dat_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then sit 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic on);
    rq_cyc_i[k] = on;
    rq_stb_i[k] = on;
  endtask

  int order [4] = '{0, 1, 3, 0};

  initial begin
    rst = 1'b1;
    rq_cyc_i = '0; rq_stb_i = '0; rq_we_i = '0; rq_cti_i = '0;
    rq_sel_i = '1; rq_adr_i = '0; rq_dat_i = '0;
    n_ack_i = 0; n_err_i = 0; n_rty_i = 0; n_vpa_i = 0; n_dat_i = '0;

    // reset state
    #1;
    chk("rst_gnt",  gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ncyc", n_cyc_o, 0);
    chk("rst_err",  rq_err_o, 0);
    #12 rst = 1'b0;

    // single read from requester 2, NIC acks after 5 cycles
    req(2, 1);
    rq_adr_i[64 +: 32] = 32'hA000_0010;
    #1 chk("rd_idle_ncyc", n_cyc_o, 0);
    step();
    chk("rd_gnt",  gnt_o, 4'b0100);
    chk("rd_busy", busy_o, 1);
    chk("rd_ncyc", n_cyc_o, 1);
    chk("rd_adr",  n_adr_o, 32'hA000_0010);
    repeat (4) step();
    chk("rd_noack", rq_ack_o, 0);
    n_ack_i = 1; n_dat_i = 32'h1234_5678;
    #1;
    chk("rd_ack", rq_ack_o, 4'b0100);
    chk("rd_dat", rq_dat_o, 32'h1234_5678);
    step();
    n_ack_i = 0;
    req(2, 0);
    #1 chk("rd_drop_ncyc", n_cyc_o, 0);
    step();
    chk("rd_gap_gnt",  gnt_o, 0);
    chk("rd_gap_busy", busy_o, 1);
    chk("rd_gap_ncyc", n_cyc_o, 0);
    step();
    chk("rd_idle", busy_o, 0);

    // contention after reset: 0,1,3 pending -> 0,1,3,0
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    req(0, 1); req(1, 1); req(3, 1);
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("ct%0d_gnt", n), gnt_o, 64'(1 << order[n]));
      chk($sformatf("ct%0d_busy", n), busy_o, 1);
      n_ack_i = 1;
      req(order[n], 0);
      #1 chk($sformatf("ct%0d_ack", n), rq_ack_o, 64'(1 << order[n]));
      step();
      n_ack_i = 0;
      chk($sformatf("ct%0d_gap_gnt", n), gnt_o, 0);
      chk($sformatf("ct%0d_gap_ncyc", n), n_cyc_o, 0);
      chk($sformatf("ct%0d_gap_busy", n), busy_o, 1);
      req(order[n], 1);
      step();
      chk($sformatf("ct%0d_idle", n), busy_o, 0);
    end
    req(0, 0); req(1, 0); req(3, 0);

    // burst from requester 1, four acked beats under one grant
    req(1, 1);
    rq_cti_i[3 +: 3] = 3'b001;
    step();
    chk("bu_gnt", gnt_o, 4'b0010);
    chk("bu_cti", n_cti_o, 3'b001);
    for (int b = 0; b < 4; b++) begin
      n_ack_i = 1;
      #1 chk($sformatf("bu%0d_ack", b), rq_ack_o, 4'b0010);
      step();
      n_ack_i = 0;
      #1 chk($sformatf("bu%0d_ack_lo", b), rq_ack_o, 0);
      chk($sformatf("bu%0d_gnt", b), gnt_o, 4'b0010);
      step();
    end
    chk("bu_ncyc", n_cyc_o, 1);
    req(1, 0);
    rq_cti_i = '0;
    step();
    chk("bu_gap_gnt", gnt_o, 0);
    step();
    chk("bu_idle", busy_o, 0);

    // timeout: counter 0..16 across BUSY cycles, abort on the next edge
    req(3, 1);
    step();
    chk("to_gnt", gnt_o, 4'b1000);
    repeat (16) step();
    chk("to_last_busy_ncyc", n_cyc_o, 1);
    chk("to_last_busy_err",  rq_err_o, 0);
    step();
    chk("to_ab_ncyc", n_cyc_o, 0);
    chk("to_ab_err",  rq_err_o, 4'b1000);
    chk("to_ab_busy", busy_o, 1);
    step();
    chk("to_ab_hold_err", rq_err_o, 4'b1000);
    req(3, 0);
    step();
    chk("to_gap_err", rq_err_o, 0);
    chk("to_gap_gnt", gnt_o, 0);
    step();
    chk("to_idle", busy_o, 0);
    req(0, 1);
    step();
    chk("to_next_gnt",  gnt_o, 4'b0001);
    chk("to_next_ncyc", n_cyc_o, 1);
    n_ack_i = 1;
    req(0, 0);
    step();
    n_ack_i = 0;
    step();
    chk("to_next_idle", busy_o, 0);

    // ack in the very cycle the counter reaches TMO
    req(2, 1);
    step();
    chk("co_gnt", gnt_o, 4'b0100);
    repeat (16) step();
    n_ack_i = 1;
    #1;
    chk("co_ack", rq_ack_o, 4'b0100);
    chk("co_err", rq_err_o, 0);
    step();
    n_ack_i = 0;
    chk("co_ncyc", n_cyc_o, 1);
    chk("co_err2", rq_err_o, 0);
    repeat (16) step();
    chk("co_cnt_clr_ncyc", n_cyc_o, 1);
    req(2, 0);
    step();
    chk("co_gap_err", rq_err_o, 0);
    chk("co_gap_gnt", gnt_o, 0);
    step();

    // asynchronous reset in the middle of BUSY
    req(0, 1);
    step();
    chk("ar_gnt", gnt_o, 4'b0001);
    #3 rst = 1'b1;
    #1;
    chk("ar_ncyc", n_cyc_o, 0);
    chk("ar_gnt0", gnt_o, 0);
    chk("ar_busy", busy_o, 0);
    #10 rst = 1'b0;
    req(1, 1);
    step();
    chk("ar_first_gnt", gnt_o, 4'b0001);
    req(0, 0); req(1, 0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
